// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: shared constants and FSM encoding for the decoder scan
// controller.
//   NUM_CH / CH_W : channel count and select width of the 2-to-4 decoder
//   TMR_W         : width of the dwell/blank down-counter
//   scan_state_e  : controller states; ST_BLANK exists only when
//                   SCAN_BLANK_EN is defined
package decoder_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int TMR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1
`ifdef SCAN_BLANK_EN
        ,
        ST_BLANK  = 2'd2
`endif
    } scan_state_e;

endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter that times dwell and blank intervals.
// Loading N yields N+1 cycles until tc, so callers load (cycles - 1).
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   load       : load load_val this cycle (has priority over counting)
//   load_val   : reload value
//   tc         : terminal count, high while the count is zero
module scan_timer
    import decoder_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             tc
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - TMR_W'(1);
    end

    assign tc = (count == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: cycles a 2-to-4 decoder across the channels enabled in
// mask, holding each for DWELL cycles with en high. With SCAN_BLANK_EN
// defined, en drops for BLANK cycles between channels; otherwise the scan
// steps straight to the next channel and en stays high.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start, stop : one-cycle scan requests (stop dominates)
//   mask        : channel enable, sampled when the channel changes
//   sel, en     : decoder select and enable (registered)
//   busy        : not idle (registered)
//   wrap        : pulse on the first cycle of a channel at index <= previous
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] mask,
    output logic [CH_W-1:0]   sel,
    output logic              en,
    output logic              busy,
    output logic              wrap
);

    localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL - 1);
    localparam logic [TMR_W-1:0] BLANK_LD = TMR_W'(BLANK - 1);

    scan_state_e      state_q, state_d;
    logic [CH_W-1:0]  sel_d, low_idx, nxt_idx;
    logic             en_d, busy_d, wrap_d;
    logic             tmr_load, tc, chan_change;
    logic [TMR_W-1:0] tmr_val;

    scan_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tc)
    );

`ifndef SCAN_BLANK_EN
    // BLANK has no effect in this build
    logic unused_blank;
    assign unused_blank = ^BLANK_LD;
`endif

    // Lowest set mask bit: first channel of a fresh scan.
    always_comb begin
        low_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (mask[k]) low_idx = CH_W'(k);
    end

    // Next set bit above sel, cyclic. Offsets are scanned far-to-near so
    // the nearest hit wins; offset NUM_CH is sel itself (single-bit mask).
    always_comb begin
        nxt_idx = sel;
        for (int k = NUM_CH; k >= 1; k--)
            if (mask[sel + CH_W'(k)]) nxt_idx = sel + CH_W'(k);
    end

    // End of the interval that precedes a channel change.
`ifdef SCAN_BLANK_EN
    assign chan_change = tc && (state_q == ST_BLANK) && !stop;
`else
    assign chan_change = tc && (state_q == ST_ACTIVE) && !stop;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel     <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
            en      <= en_d;
            busy    <= busy_d;
            wrap    <= wrap_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:
                    if (start && (mask != '0)) state_d = ST_ACTIVE;
                ST_ACTIVE:
`ifdef SCAN_BLANK_EN
                    if (tc) state_d = ST_BLANK;
                ST_BLANK:
`endif
                    if (tc) state_d = (mask != '0) ? ST_ACTIVE : ST_IDLE;
                default:
                    state_d = ST_IDLE;
            endcase
        end
    end

    // Next output values and timer control
    always_comb begin
        sel_d    = sel;
        en_d     = (state_d == ST_ACTIVE);
        busy_d   = (state_d != ST_IDLE);
        wrap_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = DWELL_LD;
        if (state_q == ST_IDLE && state_d == ST_ACTIVE) begin
            sel_d    = low_idx;
            tmr_load = 1'b1;
        end else if (chan_change && state_d == ST_ACTIVE) begin
            sel_d    = nxt_idx;
            wrap_d   = (nxt_idx <= sel);
            tmr_load = 1'b1;
        end
`ifdef SCAN_BLANK_EN
        else if (state_q == ST_ACTIVE && state_d == ST_BLANK) begin
            tmr_val  = BLANK_LD;
            tmr_load = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: scoreboard bench for decoder_scan_ctrl. A cycle-count
// reference model predicts sel/en/busy/wrap for every clock; the prediction
// is queued when inputs are driven and popped once the DUT has registered
// its outputs. Works in either build (SCAN_BLANK_EN defined or not).
module tb_decoder_scan_ctrl;

    localparam int DWELL = 4;
    localparam int BLANK = 1;

    logic       clk = 1'b0;
    logic       rst_n, start, stop;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       en, busy, wrap;

    decoder_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .mask  (mask),
        .sel   (sel),
        .en    (en),
        .busy  (busy),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic       busy;
        logic       wrap;
    } obs_t;

    obs_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // reference model state
    logic [1:0] m_sel;
    logic       m_en, m_busy, m_wrap, m_blk;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 2'd0; m_en = 1'b0; m_busy = 1'b0; m_wrap = 1'b0;
        m_blk = 1'b0; m_cnt = 0;
    endtask

    task automatic model_advance();
        logic [1:0] n;
        logic       found;
        if (mask == 4'b0000) begin
            m_busy = 1'b0; m_en = 1'b0; m_wrap = 1'b0;
        end else begin
            found = 1'b0;
            n = m_sel;
            for (int k = 1; k <= 4; k++) begin
                if (!found && mask[(int'(m_sel) + k) % 4]) begin
                    n = 2'((int'(m_sel) + k) % 4);
                    found = 1'b1;
                end
            end
            m_wrap = (n <= m_sel);
            m_sel  = n;
            m_en   = 1'b1;
            m_blk  = 1'b0;
            m_cnt  = 1;
        end
    endtask

    task automatic model_step(input logic st, input logic sp);
        m_wrap = 1'b0;
        if (sp) begin
            m_busy = 1'b0; m_en = 1'b0;
        end else if (!m_busy) begin
            if (st && mask != 4'b0000) begin
                m_busy = 1'b1; m_en = 1'b1; m_blk = 1'b0; m_cnt = 1;
                for (int k = 3; k >= 0; k--)
                    if (mask[k]) m_sel = 2'(k);
            end
        end else if (!m_blk) begin
            if (m_cnt < DWELL) m_cnt++;
            else begin
`ifdef SCAN_BLANK_EN
                m_blk = 1'b1; m_en = 1'b0; m_cnt = 1;
`else
                model_advance();
`endif
            end
        end else begin
            if (m_cnt < BLANK) m_cnt++;
            else model_advance();
        end
    endtask

    // One clock: drive inputs at negedge, predict, then compare after posedge.
    task automatic tick(input logic st, input logic sp);
        obs_t e;
        start = st;
        stop  = sp;
        model_step(st, sp);
        e.sel = m_sel; e.en = m_en; e.busy = m_busy; e.wrap = m_wrap;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        chk("sel",  sel,  e.sel);
        chk("en",   en,   e.en);
        chk("busy", busy, e.busy);
        chk("wrap", wrap, e.wrap);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},  sel,  0);
        chk({tag, "_en"},   en,   0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wrap"}, wrap, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mask = 4'b0000;
        model_reset();
        #2;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // full mask: 0,1,2,3,0 with wrap on the return to 0; start while busy
        mask = 4'b1111;
        tick(1'b1, 1'b0);
        run(6);
        tick(1'b1, 1'b0);
        run(20);
        tick(1'b0, 1'b1);
        run(2);

        // alternating 1,3,1
        mask = 4'b1010;
        tick(1'b1, 1'b0);
        run(16);
        tick(1'b0, 1'b1);

        // single channel: re-selected each period, wrap every period
        mask = 4'b0100;
        tick(1'b1, 1'b0);
        run(16);
        tick(1'b0, 1'b1);

        // start with empty mask: stays idle, sel keeps its last value
        mask = 4'b0000;
        tick(1'b1, 1'b0);
        run(2);

        // stop in the 2nd active cycle of sel=1, then restart at lowest bit
        mask = 4'b0011;
        tick(1'b1, 1'b0);
`ifdef SCAN_BLANK_EN
        run(6);
`else
        run(5);
`endif
        tick(1'b0, 1'b1);
        run(2);
        mask = 4'b0110;
        tick(1'b1, 1'b0);
        run(3);
        tick(1'b0, 1'b1);

        // mask cleared mid-scan: block drops to idle at the channel change
        mask = 4'b1111;
        tick(1'b1, 1'b0);
        run(2);
        mask = 4'b0000;
        run(8);

        // asynchronous reset in the gap after sel=1, then start+stop together
        mask = 4'b1110;
        tick(1'b1, 1'b0);
        run(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mask = 4'b1111;
        tick(1'b1, 1'b1);
        run(2);
        tick(1'b1, 1'b0);
        run(12);
        tick(1'b0, 1'b1);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
